csa_pipe_adder: RTL and testbench

- Two-stage pipelined carry-select adder with valid/ready handshakes on input and output.
- Stage 1 splits the operands into BLOCK-bit slices. For each slice it computes two speculative sums, one for carry-in 0 and one for carry-in 1, plus their carry-outs.
- Stage 2 resolves the inter-block carry chain. It does this with a chain of 2:1 select muxes (q = s ? b : a), one per sum bit and one per block carry.
- Sits between the operand source and the result consumer in the datapath.

---
 rtl/csa_pipe_adder.sv | 151 +++++++++++++++
 tb/tb_csa_pipe_adder.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/csa_pipe_adder.sv
// csa_pipe_adder: two-stage pipelined carry-select adder with valid/ready
// handshakes on both sides.
//
// Stage 1 registers speculative per-slice sums for carry-in 0 and 1.
// Stage 2 resolves the block carry chain and registers sum/cout.
//
// Parameters:
//   WIDTH - operand/sum width (must be a multiple of BLOCK)
//   BLOCK - slice width
//
// Ports:
//   clk, rst_n          - clock, async active-low reset
//   in_valid, in_ready  - operand handshake
//   a, b, cin           - unsigned operands and carry-in
//   out_valid, out_ready- result handshake
//   sum, cout           - (a + b + cin) mod 2^WIDTH and carry-out
//   ovf                 - signed overflow (only when CSA_OVERFLOW_EN is defined)
//
// Optional feature macro: CSA_OVERFLOW_EN
module csa_pipe_adder #(
    parameter int WIDTH = 16,
    parameter int BLOCK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef CSA_OVERFLOW_EN
    ,
    output logic             ovf
`endif
);

    localparam int NBLK = (WIDTH / BLOCK < 1) ? 1 : WIDTH / BLOCK;

    if (BLOCK < 1 || WIDTH < BLOCK || (WIDTH % BLOCK) != 0) begin : g_bad_cfg
        $error("csa_pipe_adder: WIDTH must be a nonzero multiple of BLOCK");
    end

    // Stage 1 state
    logic [NBLK-1:0][BLOCK:0] s0_q, s1_q;
    logic [NBLK-1:0][BLOCK:0] s0_d, s1_d;
    logic                     cin_q;
    logic                     s1_valid;
    logic                     rdy_q;

    // Handshake
    logic adv2;
    logic in_fire;

    assign adv2     = !out_valid || out_ready;
    // rdy_q holds in_ready low for the first cycle after reset release
    assign in_ready = rdy_q && (!s1_valid || adv2);
    assign in_fire  = in_valid && in_ready;

    // Speculative slice sums. Slice 0 already folds in cin, so both of
    // its copies are identical and the select in stage 2 is a no-op there.
    always_comb begin
        logic [BLOCK:0] ak, bk, c0, c1;
        s0_d = '0;
        s1_d = '0;
        for (int k = 0; k < NBLK; k++) begin
            ak = {1'b0, a[k*BLOCK +: BLOCK]};
            bk = {1'b0, b[k*BLOCK +: BLOCK]};
            c0 = (k == 0) ? (BLOCK+1)'(cin) : '0;
            c1 = (k == 0) ? (BLOCK+1)'(cin) : (BLOCK+1)'(1);
            s0_d[k] = ak + bk + c0;
            s1_d[k] = ak + bk + c1;
        end
    end

`ifdef CSA_OVERFLOW_EN
    // Carry into the MSB recovered as sum_msb ^ a_msb ^ b_msb, per case
    logic mc0_q, mc1_q;
    logic mc0_d, mc1_d;
    assign mc0_d = s0_d[NBLK-1][BLOCK-1] ^ a[WIDTH-1] ^ b[WIDTH-1];
    assign mc1_d = s1_d[NBLK-1][BLOCK-1] ^ a[WIDTH-1] ^ b[WIDTH-1];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0_q     <= '0;
            s1_q     <= '0;
            cin_q    <= 1'b0;
            s1_valid <= 1'b0;
            rdy_q    <= 1'b0;
`ifdef CSA_OVERFLOW_EN
            mc0_q    <= 1'b0;
            mc1_q    <= 1'b0;
`endif
        end else begin
            rdy_q    <= 1'b1;
            s1_valid <= in_fire || (s1_valid && !adv2);
            if (in_fire) begin
                s0_q  <= s0_d;
                s1_q  <= s1_d;
                cin_q <= cin;
`ifdef CSA_OVERFLOW_EN
                mc0_q <= mc0_d;
                mc1_q <= mc1_d;
`endif
            end
        end
    end

    // Stage 2 carry resolution: one select per sum bit and per block carry
    logic [NBLK:0]    c;
    logic [WIDTH-1:0] sum_d;

    always_comb begin
        c     = '0;
        sum_d = '0;
        c[0]  = cin_q;
        for (int k = 0; k < NBLK; k++) begin
            sum_d[k*BLOCK +: BLOCK] = c[k] ? s1_q[k][BLOCK-1:0]
                                           : s0_q[k][BLOCK-1:0];
            c[k+1] = c[k] ? s1_q[k][BLOCK] : s0_q[k][BLOCK];
        end
    end

`ifdef CSA_OVERFLOW_EN
    logic ovf_d;
    assign ovf_d = (c[NBLK-1] ? mc1_q : mc0_q) ^ c[NBLK];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
`ifdef CSA_OVERFLOW_EN
            ovf       <= 1'b0;
`endif
        end else if (adv2) begin
            out_valid <= s1_valid;
            sum       <= sum_d;
            cout      <= c[NBLK];
`ifdef CSA_OVERFLOW_EN
            ovf       <= ovf_d;
`endif
        end
    end

endmodule

// File: tb/tb_csa_pipe_adder.sv
// tb_csa_pipe_adder: directed self-checking bench for csa_pipe_adder
// (WIDTH=16, BLOCK=4); ovf checks are compiled in with CSA_OVERFLOW_EN.
module tb_csa_pipe_adder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a, b;
    logic        cin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
`ifdef CSA_OVERFLOW_EN
    logic        ovf;
`endif

    int ntests = 0;
    int nfail  = 0;

    always #5 clk = ~clk;

    csa_pipe_adder #(.WIDTH(16), .BLOCK(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
`ifdef CSA_OVERFLOW_EN
        ,
        .ovf       (ovf)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One isolated transfer with out_ready=1; checks the 2-edge latency
    task automatic run1(input string tag, input logic [15:0] va,
                        input logic [15:0] vb, input logic vc,
                        input logic [15:0] es, input logic ec,
                        input logic eo);
        a = va; b = vb; cin = vc; in_valid = 1'b1; out_ready = 1'b1;
        chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        chk({tag, "_v1"}, 32'(out_valid), 32'd0);
        step();
        chk({tag, "_v2"}, 32'(out_valid), 32'd1);
        chk({tag, "_sum"}, 32'(sum), 32'(es));
        chk({tag, "_cout"}, 32'(cout), 32'(ec));
`ifdef CSA_OVERFLOW_EN
        chk({tag, "_ovf"}, 32'(ovf), 32'(eo));
`else
        if (eo === 1'bx) $display("unreachable");
`endif
    endtask

    initial begin
        logic [16:0] q[$];
        logic [16:0] e;
        logic [15:0] ra, rb;
        logic        rc;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0;
        #12;
        chk("rst_ov", 32'(out_valid), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_rdy", 32'(in_ready), 32'd0);
`ifdef CSA_OVERFLOW_EN
        chk("rst_ovf", 32'(ovf), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_rdy0", 32'(in_ready), 32'd0);
        step();
        chk("rel_rdy1", 32'(in_ready), 32'd1);

        run1("wrap", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        run1("cin1", 16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0);
        run1("ripple", 16'h0FFF, 16'h0000, 1'b1, 16'h1000, 1'b0, 1'b0);
        run1("ovf_pos", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        run1("ovf_neg", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
        run1("no_ovf", 16'h0001, 16'hFFFF, 1'b0, 16'h0000, 1'b1, 1'b0);

        // Back-to-back random stream
        out_ready = 1'b1;
        for (int i = 0; i <= 100; i++) begin
            if (i < 100) begin
                ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
                a = ra; b = rb; cin = rc; in_valid = 1'b1;
                q.push_back(17'(ra) + 17'(rb) + 17'(rc));
                chk("stream_rdy", 32'(in_ready), 32'd1);
            end else begin
                in_valid = 1'b0;
            end
            step();
            if (i >= 1) begin
                e = q.pop_front();
                chk("stream_v", 32'(out_valid), 32'd1);
                chk("stream_res", 32'({cout, sum}), 32'(e));
            end
        end

        // Backpressure
        in_valid = 1'b0;
        step();
        chk("bp_empty", 32'(out_valid), 32'd0);
        out_ready = 1'b0;
        a = 16'h0001; b = 16'h0001; cin = 1'b0; in_valid = 1'b1;
        step();
        a = 16'h0002; b = 16'h0002;
        chk("bp_rdy1", 32'(in_ready), 32'd1);
        step();
        a = 16'h0003; b = 16'h0003;
        for (int i = 0; i < 3; i++) begin
            chk("bp_rdy0", 32'(in_ready), 32'd0);
            chk("bp_v", 32'(out_valid), 32'd1);
            chk("bp_hold", 32'(sum), 32'h0002);
            step();
        end
        chk("bp_hold4", 32'(sum), 32'h0002);
        out_ready = 1'b1;
        #1;
        chk("bp_rdy_rel", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        chk("bp_o2v", 32'(out_valid), 32'd1);
        chk("bp_o2", 32'(sum), 32'h0004);
        step();
        chk("bp_o3v", 32'(out_valid), 32'd1);
        chk("bp_o3", 32'(sum), 32'h0006);
        step();
        chk("bp_nodup", 32'(out_valid), 32'd0);

        // Reset with two results in flight
        a = 16'h0005; b = 16'h0005; cin = 1'b0; in_valid = 1'b1;
        step();
        a = 16'h0006; b = 16'h0006;
        step();
        in_valid = 1'b0;
        out_ready = 1'b0;
        chk("mid_v", 32'(out_valid), 32'd1);
        chk("mid_sum", 32'(sum), 32'h000A);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst_v", 32'(out_valid), 32'd0);
        chk("mrst_sum", 32'(sum), 32'd0);
        chk("mrst_cout", 32'(cout), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        step();
        chk("post_v1", 32'(out_valid), 32'd0);
        step();
        chk("post_v2", 32'(out_valid), 32'd0);
        run1("post", 16'h0007, 16'h0008, 1'b0, 16'h000F, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
